input_buffer: RTL

INPUT_BUFFER -- requirements
Module: input_buffer

---
 rtl/noc_params.sv | 31 +++
 rtl/rc_unit.sv | 28 ++
 rtl/input_buffer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/noc_params.sv
// Shared NoC types: flit layout, flit labels, router ports.
package noc_params;

    localparam int DEST_ADDR_SIZE = 4;
    localparam int VC_SIZE = 2;
    localparam int PAYLOAD_SIZE = 8;

    typedef enum logic [1:0] {
        HEAD,
        BODY,
        TAIL,
        HEADTAIL
    } flit_label_t;

    typedef enum logic [2:0] {
        LOCAL,
        NORTH,
        SOUTH,
        WEST,
        EAST
    } port_t;

    typedef struct packed {
        flit_label_t flit_label;
        logic [VC_SIZE-1:0] vc_id;
        logic [DEST_ADDR_SIZE-1:0] x_dest;
        logic [DEST_ADDR_SIZE-1:0] y_dest;
        logic [PAYLOAD_SIZE-1:0] payload;
    } flit_t;

endpackage

// File: rtl/rc_unit.sv
// Dimension-ordered (X then Y) route computation.
module rc_unit
    import noc_params::*;
#(
    parameter int X_CURRENT = 0,
    parameter int Y_CURRENT = 0
) (
    input  logic [DEST_ADDR_SIZE-1:0] x_dest,
    input  logic [DEST_ADDR_SIZE-1:0] y_dest,
    output port_t                     out_port
);

    localparam logic [DEST_ADDR_SIZE-1:0] XC = DEST_ADDR_SIZE'(X_CURRENT);
    localparam logic [DEST_ADDR_SIZE-1:0] YC = DEST_ADDR_SIZE'(Y_CURRENT);

    always_comb begin
        out_port = LOCAL;
        if (x_dest > XC)
            out_port = EAST;
        else if (x_dest < XC)
            out_port = WEST;
        else if (y_dest > YC)
            out_port = SOUTH;
        else if (y_dest < YC)
            out_port = NORTH;
    end

endmodule

// File: rtl/input_buffer.sv
// Router input port: flit FIFO plus per-packet VA/SA control.
module input_buffer
    import noc_params::*;
#(
    parameter int BUFFER_SIZE = 8,
    parameter int X_CURRENT = 0,
    parameter int Y_CURRENT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  flit_t              data_i,
    input  logic               valid_i,
    input  logic               read_i,
    input  logic               vc_valid_i,
    input  logic [VC_SIZE-1:0] vc_new_i,
    output flit_t              data_o,
    output port_t              out_port_o,
    output logic               va_request_o,
    output logic               sa_request_o,
    output logic               is_full_o,
    output logic               is_empty_o,
    output logic               error_o
);

    localparam int PW = $clog2(BUFFER_SIZE);
    localparam logic [PW:0] DEPTH = (PW+1)'(BUFFER_SIZE);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] VA     = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;

    flit_t mem [BUFFER_SIZE];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0] count;
    logic [1:0] state;
    logic [VC_SIZE-1:0] vc;
    logic hdr_sent;
    port_t route;
    flit_t head;

    logic empty, full, is_head, is_tail;
    logic pop_ok, discard, pop, push;
    logic bad_read, overflow, stray_head;

    assign head = mem[rd_ptr];
    assign empty = (count == '0);
    assign full = (count == DEPTH);
    assign is_head = (head.flit_label == HEAD) ||
                     (head.flit_label == HEADTAIL);
    assign is_tail = (head.flit_label == TAIL) ||
                     (head.flit_label == HEADTAIL);

    // An orphan body/tail at the head in IDLE is drained like a pop.
    assign pop_ok = read_i && (state == ACTIVE) && !empty;
    assign discard = (state == IDLE) && !empty && !is_head;
    assign pop = pop_ok || discard;
    assign push = valid_i && (!full || pop);

    assign bad_read = read_i && !pop_ok;
    assign overflow = valid_i && full && !pop;
    // hdr_sent marks that this packet's own header already left.
    assign stray_head = (state == ACTIVE) && hdr_sent &&
                        !empty && is_head;

    rc_unit #(
        .X_CURRENT(X_CURRENT),
        .Y_CURRENT(Y_CURRENT)
    ) u_rc (
        .x_dest  (head.x_dest),
        .y_dest  (head.y_dest),
        .out_port(route)
    );

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            out_port_o <= LOCAL;
            vc <= '0;
            hdr_sent <= 1'b0;
            error_o <= 1'b0;
        end else begin
            if (bad_read || overflow || discard || stray_head)
                error_o <= 1'b1;
            unique case (state)
                IDLE: begin
                    hdr_sent <= 1'b0;
                    if (!empty && is_head) begin
                        state <= VA;
                        out_port_o <= route;
                    end
                end
                VA: begin
                    if (vc_valid_i) begin
                        state <= ACTIVE;
                        vc <= vc_new_i;
                    end
                end
                ACTIVE: begin
                    if (pop_ok) begin
                        hdr_sent <= 1'b1;
                        if (is_tail)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        data_o = head;
        data_o.vc_id = vc;
    end

    assign va_request_o = (state == VA);
    assign sa_request_o = (state == ACTIVE) && !empty;
    assign is_full_o = full;
    assign is_empty_o = empty;

endmodule
